// File: rtl/ring_osc_sampler.sv
// Multi-ring oscillator sampler: per-ring high-time counts over a 2^WINDOW_LOG2
// window, plus an XOR-combined raw stream debiased with a von Neumann extractor.

module ring_osc_ring #(
  parameter int STAGES = 100
) (
  input  logic i_clk,
  output logic o_osc
);
`ifdef SYNTHESIS
  (* keep *) logic [STAGES-1:0] w_dly;

  assign w_dly[0] = ~w_dly[STAGES-1];
  for (genvar s = 1; s < STAGES; s++) begin : g_buf
    assign w_dly[s] = w_dly[s-1];
  end
  assign o_osc = w_dly[0];
`else
  // Simulators cannot settle a combinational ring; stand in with a free-running
  // toggle whose half-period tracks the stage count. Never reset, like the ring.
  logic [15:0] r_div;
  logic        r_osc;

  always_ff @(posedge i_clk) begin
    if (r_div == 16'(STAGES - 1)) begin
      r_div <= '0;
      r_osc <= ~r_osc;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end
  assign o_osc = r_osc;
`endif
endmodule

module ring_osc_sampler #(
  parameter int NUM_RINGS   = 4,
  parameter int DELAY_BASE  = 100,
  parameter int DELAY_STEP  = 6,
  parameter int CNT_WIDTH   = 16,
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_continuous,
  input  logic                           i_test_en,
  input  logic [NUM_RINGS-1:0]           i_test_in,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [NUM_RINGS*CNT_WIDTH-1:0] o_count_out,
  output logic [NUM_RINGS-1:0]           o_ovf,
  output logic                           o_rand_bit,
  output logic                           o_rand_valid
);
  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_REPORT} state_t;

  state_t                              r_state, w_next;
  logic                                w_load;
  logic [NUM_RINGS-1:0]                w_osc, w_src, r_sync0, r_wobble;
  logic [NUM_RINGS-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [WINDOW_LOG2-1:0]              r_win;
  logic                                r_raw_q, r_phase, r_first;

  for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
    ring_osc_ring #(.STAGES(DELAY_BASE + i*DELAY_STEP)) u_ring (
      .i_clk (i_clk),
      .o_osc (w_osc[i])
    );
  end

  assign w_src = i_test_en ? i_test_in : w_osc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0  <= '0;
      r_wobble <= '0;
    end else begin
      r_sync0  <= w_src;
      r_wobble <= r_sync0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:    if (i_start) begin
                   w_next = S_MEASURE;
                   w_load = 1'b1;
                 end
      S_MEASURE: if (r_win == '0) w_next = S_REPORT;
      S_REPORT:  if (i_continuous) begin
                   w_next = S_MEASURE;
                   w_load = 1'b1;
                 end else begin
                   w_next = S_IDLE;
                 end
      default:   w_next = S_IDLE;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      o_ovf <= '0;
      r_win <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
      o_ovf <= '0;
      r_win <= '1;
    end else if (r_state == S_MEASURE) begin
      r_win <= r_win - 1'b1;
      for (int i = 0; i < NUM_RINGS; i++) begin
        if (r_wobble[i]) begin
          if (r_cnt[i] == '1) o_ovf[i] <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Snapshot happens on the same edge that may reload counters for the next window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count_out <= '0;
      o_done      <= 1'b0;
    end else begin
      o_done <= (r_state == S_REPORT);
      if (r_state == S_REPORT) o_count_out <= r_cnt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_raw_q      <= 1'b0;
      r_phase      <= 1'b0;
      r_first      <= 1'b0;
      o_rand_bit   <= 1'b0;
      o_rand_valid <= 1'b0;
    end else begin
      r_raw_q      <= ^r_wobble;
      r_phase      <= ~r_phase;
      o_rand_valid <= r_phase && (r_first != r_raw_q);
      if (!r_phase) r_first <= r_raw_q;
      if (r_phase && (r_first != r_raw_q)) o_rand_bit <= r_first;
    end
  end
endmodule
